// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the iterative multiply/divide unit
package mdu_pkg;

    localparam int MDU_WIDTH = 16;
    localparam int MDU_LAT   = MDU_WIDTH + 1;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } mdu_state_t;

    function automatic logic mdu_is_div(input mdu_op_t op);
        return op[1];
    endfunction

    // MULHU and REMU both return the upper accumulator half
    function automatic logic mdu_takes_high(input mdu_op_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - execute-stage request/response bundle for the multiply/divide unit
interface mdu_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) ();

    logic             start_i;
    mdu_op_t          op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             ready_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             illegal_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  ready_o, done_o, result_o, illegal_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output ready_o, done_o, result_o, illegal_o
    );

endinterface

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step
module mdu_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_msb,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    assign w_shifted = {i_rem, i_msb};
    // MSB of the WIDTH+1 bit difference is the borrow: set when shifted remainder < divisor
    assign w_diff    = w_shifted - {1'b0, i_div};
    assign o_q       = ~w_diff[WIDTH];
    assign o_rem     = o_q ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative unsigned MUL/MULHU/DIVU/REMU; divide built only with MDU_DIV_EN
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input logic  clk,
    input logic  rst_n,
    mdu_if.slave bus
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    mdu_state_t         r_state;
    mdu_state_t         w_next;
    mdu_op_t            r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_ready;
    logic               r_done;
    logic               r_illegal;
    logic [WIDTH-1:0]   r_result;

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_acc;

    // Shift-add: multiplicand joins the upper half, then the whole accumulator shifts right
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : {WIDTH{1'b0}})};
    assign w_mul_acc = {w_sum, r_acc[WIDTH-1:1]};

`ifdef MDU_DIV_EN
    logic [WIDTH-1:0]   w_rem_next;
    logic               w_q;
    logic [2*WIDTH-1:0] w_div_acc;

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem (r_acc[2*WIDTH-1:WIDTH]),
        .i_msb (r_a[WIDTH-1]),
        .i_div (r_b),
        .o_rem (w_rem_next),
        .o_q   (w_q)
    );

    // Upper half holds the remainder, lower half collects quotient bits
    assign w_div_acc = {w_rem_next, r_acc[WIDTH-2:0], w_q};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_i) begin
`ifdef MDU_DIV_EN
                    w_next = ST_RUN;
`else
                    w_next = mdu_is_div(bus.op_i) ? ST_DONE : ST_RUN;
`endif
                end
            end
            ST_RUN:  if (r_cnt == LAST) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (bus.flush_i) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= OP_MUL;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_result  <= '0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            if (bus.flush_i) begin
                r_ready <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start_i) begin
                            r_op    <= bus.op_i;
                            r_a     <= bus.a_i;
                            r_b     <= bus.b_i;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_ready <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        r_cnt <= r_cnt + CW'(1);
`ifdef MDU_DIV_EN
                        if (mdu_is_div(r_op)) begin
                            r_acc <= w_div_acc;
                            r_a   <= r_a << 1;
                        end else
`endif
                        begin
                            r_acc <= w_mul_acc;
                            r_b   <= r_b >> 1;
                        end
                    end
                    ST_DONE: begin
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
`ifndef MDU_DIV_EN
                        if (mdu_is_div(r_op)) begin
                            r_result  <= '0;
                            r_illegal <= 1'b1;
                        end else
`endif
                        r_result <= mdu_takes_high(r_op) ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
                    end
                    default: r_ready <= 1'b1;
                endcase
            end
        end
    end

    assign bus.ready_o   = r_ready;
    assign bus.done_o    = r_done;
    assign bus.result_o  = r_result;
    assign bus.illegal_o = r_illegal;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - scoreboard bench for mdu_iterative (both MDU_DIV_EN builds)
module tb_mdu_iterative;
    import mdu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_if #(.WIDTH(16)) bus ();

    mdu_iterative #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] res;
        logic        ill;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc      = 0;
    int          n_vec    = 0;
    int          n_bad    = 0;
    logic [15:0] last_res = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", {16'h0, bus.result_o}, {16'h0, e.res});
                check("illegal", {31'h0, bus.illegal_o}, {31'h0, e.ill});
                check("latency", cyc, e.due);
            end
        end
    end

    task automatic run_op(input mdu_op_t op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] r, input bit ill, input int lat,
                          input bit pulse, input string name);
        int due;
        bit rlow;
        @(negedge clk);
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.start_i = 1'b1;
        due = cyc + 1 + lat;
        exp_q.push_back('{r, ill, due});
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.a_i     = ~a;
        bus.b_i     = ~b;
        rlow = 1'b1;
        while (cyc < due) begin
            if (bus.ready_o) rlow = 1'b0;
            if (pulse && cyc == due - 8) begin
                bus.start_i = 1'b1;
                bus.op_i    = OP_MULHU;
                bus.a_i     = 16'h0002;
                bus.b_i     = 16'h0003;
            end else begin
                bus.start_i = 1'b0;
            end
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        check({name, "_ready_low"}, {31'h0, rlow}, 32'd1);
        @(negedge clk);
        check({name, "_done_seen"}, exp_q.size(), 32'd0);
        check({name, "_ready_after"}, {31'h0, bus.ready_o}, 32'd1);
        exp_q.delete();
        last_res = r;
    endtask

    task automatic run_div(input mdu_op_t op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] r, input string name);
        run_op(op, a, b, DIV_EN ? r : 16'h0000, !DIV_EN, DIV_EN ? MDU_LAT : 1, 1'b0, name);
    endtask

    task automatic watch_no_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (bus.done_o) seen = 1'b1;
        end
        check({name, "_no_done"}, {31'h0, seen}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start_i = 1'b0;
        bus.op_i    = OP_MUL;
        bus.a_i     = 16'h0000;
        bus.b_i     = 16'h0000;
        bus.flush_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready",   {31'h0, bus.ready_o},   32'd1);
        check("rst_done",    {31'h0, bus.done_o},    32'd0);
        check("rst_result",  {16'h0, bus.result_o},  32'd0);
        check("rst_illegal", {31'h0, bus.illegal_o}, 32'd0);
        rst_n = 1'b1;

        run_op(OP_MUL,   16'h1234, 16'h0010, 16'h2340, 1'b0, MDU_LAT, 1'b0, "mul");
        run_op(OP_MULHU, 16'h1234, 16'h0010, 16'h0001, 1'b0, MDU_LAT, 1'b0, "mulhu");
        run_div(OP_DIVU, 16'h0064, 16'h0007, 16'h000E, "divu");
        run_div(OP_REMU, 16'h0064, 16'h0007, 16'h0002, "remu");
        run_div(OP_DIVU, 16'h00AB, 16'h0000, 16'hFFFF, "divu_zero");
        run_div(OP_REMU, 16'h00AB, 16'h0000, 16'h00AB, "remu_zero");

        // flush a MUL a few cycles into RUN
        @(negedge clk);
        bus.op_i    = OP_MUL;
        bus.a_i     = 16'hFFFF;
        bus.b_i     = 16'hFFFF;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_ready",  {31'h0, bus.ready_o},  32'd1);
        check("flush_result", {16'h0, bus.result_o}, {16'h0, last_res});
        watch_no_done("flush");

        run_op(OP_MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, MDU_LAT, 1'b0, "mulhu_max");
        run_op(OP_MUL,   16'h00FF, 16'h0101, 16'hFFFF, 1'b0, MDU_LAT, 1'b1, "mul_midstart");

        // start together with flush while idle
        @(negedge clk);
        bus.op_i    = OP_MUL;
        bus.a_i     = 16'h0003;
        bus.b_i     = 16'h0005;
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        check("startflush_ready",  {31'h0, bus.ready_o},  32'd1);
        check("startflush_result", {16'h0, bus.result_o}, {16'h0, last_res});
        watch_no_done("startflush");

        run_op(OP_MULHU, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, MDU_LAT, 1'b0, "mulhu_small");
        run_op(OP_MUL,   16'h0000, 16'h1234, 16'h0000, 1'b0, MDU_LAT, 1'b0, "mul_zero");
        run_op(OP_MUL,   16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, MDU_LAT, 1'b0, "mul_max");

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        bus.op_i    = OP_MULHU;
        bus.a_i     = 16'h1234;
        bus.b_i     = 16'h5678;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready",   {31'h0, bus.ready_o},   32'd1);
        check("arst_done",    {31'h0, bus.done_o},    32'd0);
        check("arst_result",  {16'h0, bus.result_o},  32'd0);
        check("arst_illegal", {31'h0, bus.illegal_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
